// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_unit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.          |
// |   Stalls the pipeline while busy; zero-divisor and overflow finish in 1.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartE,
    input  logic [1:0]       DivOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             DivBusy,
    output logic             DivDone,
    output logic [WIDTH-1:0] DivResult
);

    localparam int               c_CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_RUN     = 2'd1;
    localparam logic [1:0]       c_DONE    = 2'd2;
    localparam logic [WIDTH-1:0] c_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [1:0]         r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_div;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;

    logic               w_start;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_div0;
    logic               w_ovf;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_res;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_fit;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quot_nx;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic [WIDTH-1:0]   w_final;

    // A start is never taken while reset is held.
    assign w_start   = StartE & ~FlushE & ~rst;
    assign w_signed  = ~DivOpE[0];
    assign w_a_neg   = w_signed & SrcAE[WIDTH-1];
    assign w_b_neg   = w_signed & SrcBE[WIDTH-1];
    assign w_div0    = (SrcBE == '0);
    assign w_ovf     = w_signed & (SrcAE == c_INT_MIN) & (SrcBE == '1);
    assign w_special = w_div0 | w_ovf;
    assign w_abs_a   = w_a_neg ? -SrcAE : SrcAE;
    assign w_abs_b   = w_b_neg ? -SrcBE : SrcBE;

    always_comb begin
        w_special_res = '0;
        if (w_div0) begin
            w_special_res = DivOpE[1] ? SrcAE : '1;
        end else if (w_ovf) begin
            w_special_res = DivOpE[1] ? '0 : c_INT_MIN;
        end
    end

    // Shifted partial remainder can reach WIDTH+1 bits when the divisor MSB is set.
    assign w_fit     = ({r_rem, r_quot[WIDTH-1]} >= {1'b0, r_div});
    assign w_rem_nx  = w_fit ? ({r_rem[WIDTH-2:0], r_quot[WIDTH-1]} - r_div)
                             : {r_rem[WIDTH-2:0], r_quot[WIDTH-1]};
    assign w_quot_nx = {r_quot[WIDTH-2:0], w_fit};
    assign w_q_fix   = r_neg_q ? -w_quot_nx : w_quot_nx;
    assign w_r_fix   = r_neg_r ? -w_rem_nx : w_rem_nx;
    assign w_final   = r_op[1] ? w_r_fix : w_q_fix;

    always_comb begin
        w_next_state = r_state;
        DivBusy      = 1'b0;
        DivDone      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    DivBusy      = 1'b1;
                    w_next_state = w_special ? c_DONE : c_RUN;
                end
            end
            c_RUN: begin
                DivBusy = 1'b1;
                if (FlushE) begin
                    w_next_state = c_IDLE;
                end else if (r_cnt == '0) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                DivDone      = ~FlushE;
                w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_op    <= DivOpE;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_rem   <= '0;
                        r_quot  <= w_abs_a;
                        r_div   <= w_abs_b;
                        r_cnt   <= c_CNT_W'(WIDTH - 1);
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                c_RUN: begin
                    if (!FlushE) begin
                        r_rem  <= w_rem_nx;
                        r_quot <= w_quot_nx;
                        r_cnt  <= r_cnt - c_CNT_W'(1);
                        if (r_cnt == '0) begin
                            r_result <= w_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign DivResult = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_div_unit: scoreboard bench for div_unit with directed vectors.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_div_unit;

    localparam int W = 32;
    localparam logic [1:0] c_DIV  = 2'b00;
    localparam logic [1:0] c_DIVU = 2'b01;
    localparam logic [1:0] c_REM  = 2'b10;
    localparam logic [1:0] c_REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         StartE;
    logic [1:0]   DivOpE;
    logic [W-1:0] SrcAE;
    logic [W-1:0] SrcBE;
    logic         FlushE;
    logic         DivBusy;
    logic         DivDone;
    logic [W-1:0] DivResult;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .StartE    (StartE),
        .DivOpE    (DivOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .FlushE    (FlushE),
        .DivBusy   (DivBusy),
        .DivDone   (DivDone),
        .DivResult (DivResult)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DivDone strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && DivDone) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got DivDone=1 result=%h want no completion (cycle %0d)",
                         DivResult, cyc);
            end else begin
                e = sb.pop_front();
                chk("result", DivResult, e.res);
                chk("done_cycle", W'(cyc), W'(e.cyc));
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int lat);
        int t;
        exp_t e;
        @(posedge clk);
        #1;
        StartE = 1'b1;
        DivOpE = op;
        SrcAE  = a;
        SrcBE  = b;
        t      = cyc;
        e.res  = exp;
        e.cyc  = t + lat;
        sb.push_back(e);
        @(negedge clk);
        chk("busy_issue", W'(DivBusy), W'(1));
        @(posedge clk);
        #1;
        StartE = 1'b0;
        SrcAE  = $urandom;
        SrcBE  = $urandom;
        DivOpE = 2'($urandom);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("busy_run", W'(DivBusy), W'(k < lat));
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t;
        exp_t e;
        rst    = 1'b1;
        StartE = 1'b0;
        DivOpE = 2'b00;
        SrcAE  = '0;
        SrcBE  = '0;
        FlushE = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", W'(DivBusy), W'(0));
        chk("rst_done", W'(DivDone), W'(0));
        chk("rst_result", DivResult, W'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        run_op(c_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op(c_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op(c_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33);
        run_op(c_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33);
        run_op(c_DIV, 32'd7, -32'sd2, 32'hFFFF_FFFD, 33);
        run_op(c_REM, 32'd7, -32'sd2, 32'd1, 33);
        run_op(c_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_op(c_REM, 32'h1234, 32'd0, 32'h1234, 1);
        run_op(c_DIV, -32'sd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op(c_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op(c_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run_op(c_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_op(c_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
        run_op(c_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
        run_op(c_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

        // Flush during RUN, no restart: stall drops and no completion appears.
        @(posedge clk);
        #1;
        StartE = 1'b1; DivOpE = c_DIVU; SrcAE = 32'd1000; SrcBE = 32'd3; t = cyc;
        @(posedge clk);
        #1 StartE = 1'b0;
        repeat (9) @(posedge clk);
        #1 FlushE = 1'b1;
        @(negedge clk);
        chk("flush_busy_k", W'(DivBusy), W'(1));
        chk("flush_cycle", W'(cyc), W'(t + 10));
        @(posedge clk);
        #1 FlushE = 1'b0;
        @(negedge clk);
        chk("flush_busy_k1", W'(DivBusy), W'(0));
        idle_cycles(40);
        chk("result_held", DivResult, 32'hC000_0000);

        // Flush during RUN with a new divide issued the very next cycle.
        @(posedge clk);
        #1;
        StartE = 1'b1; DivOpE = c_DIVU; SrcAE = 32'd1000; SrcBE = 32'd3; t = cyc;
        @(posedge clk);
        #1 StartE = 1'b0;
        repeat (9) @(posedge clk);
        #1 FlushE = 1'b1;
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        StartE = 1'b1; DivOpE = c_DIVU; SrcAE = 32'd9; SrcBE = 32'd3;
        e.res = 32'd3;
        e.cyc = t + 44;
        sb.push_back(e);
        @(negedge clk);
        chk("restart_busy", W'(DivBusy), W'(1));
        @(posedge clk);
        #1 StartE = 1'b0;
        idle_cycles(40);

        // Flush while in DONE suppresses the strobe.
        @(posedge clk);
        #1;
        StartE = 1'b1; DivOpE = c_DIVU; SrcAE = 32'd50; SrcBE = 32'd5;
        @(posedge clk);
        #1 StartE = 1'b0;
        repeat (32) @(posedge clk);
        #1 FlushE = 1'b1;
        @(negedge clk);
        chk("done_flush_done", W'(DivDone), W'(0));
        chk("done_flush_busy", W'(DivBusy), W'(0));
        @(posedge clk);
        #1 FlushE = 1'b0;
        idle_cycles(3);

        // Start and flush together: not accepted.
        @(posedge clk);
        #1;
        StartE = 1'b1; FlushE = 1'b1; DivOpE = c_DIVU; SrcAE = 32'd8; SrcBE = 32'd2;
        @(negedge clk);
        chk("start_flush_busy", W'(DivBusy), W'(0));
        @(posedge clk);
        #1;
        StartE = 1'b0; FlushE = 1'b0;
        @(negedge clk);
        chk("start_flush_after", W'(DivBusy), W'(0));
        idle_cycles(40);

        run_op(c_DIVU, 32'd77, 32'd7, 32'd11, 33);

        // Asynchronous reset mid-RUN.
        @(posedge clk);
        #1;
        StartE = 1'b1; DivOpE = c_DIVU; SrcAE = 32'd500; SrcBE = 32'd4;
        @(posedge clk);
        #1 StartE = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        StartE = 1'b1;
        #1;
        chk("arst_busy", W'(DivBusy), W'(0));
        chk("arst_done", W'(DivDone), W'(0));
        chk("arst_result", DivResult, W'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_busy", W'(DivBusy), W'(0));
        #2;
        rst = 1'b0;
        StartE = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", W'(DivBusy), W'(0));
        idle_cycles(40);
        chk("post_rst_result", DivResult, W'(0));

        run_op(c_DIVU, 32'd1000, 32'd10, 32'd100, 33);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL pending: got %0d outstanding results want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
